// File: rtl/fp_to_linear.sv
// fp_to_linear: sequential decoder from the 1/3/4-bit float format to a
// 12-bit two's-complement linear value, one significand shift per cycle.
module fp_to_linear (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        S,
  input  logic [2:0]  E,
  input  logic [3:0]  F,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] D
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIX   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] mag_q, mag_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic [11:0] d_q, d_d;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= 12'd0;
      cnt_q   <= 3'd0;
      sgn_q   <= 1'b0;
      d_q     <= 12'd0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      d_q     <= d_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_d   = {8'b0000_0000, F};
          cnt_d   = E;
          sgn_d   = S;
          state_d = (E != 3'd0) ? SHIFT : FIX;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        mag_d = {mag_q[10:0], 1'b0};
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = FIX;
        end else begin
          state_d = SHIFT;
        end
      end
      FIX: begin
        // Negating a zero magnitude wraps back to zero, so no negative zero.
        d_d     = sgn_q ? (~mag_q + 12'd1) : mag_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign D         = d_q;

endmodule

// File: tb/tb_fp_to_linear.sv
// Directed self-checking bench for fp_to_linear: latency, values, backpressure,
// asynchronous reset mid-shift and back-to-back throughput.
module tb_fp_to_linear;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] D;

  int total = 0;
  int bad   = 0;

  fp_to_linear dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic s, input int e, input int f);
    int v;
    v = f * (1 << e);
    if (s) v = -v;
    return v[11:0];
  endfunction

  // Called at a negedge with the block idle; returns at the negedge after accept.
  task automatic send(input logic s, input logic [2:0] e, input logic [3:0] f);
    S = s; E = e; F = f; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid; notes any in_ready seen meanwhile.
  task automatic wait_valid(output int lat, output logic saw_ready);
    lat = 0;
    saw_ready = 1'b0;
    while (!out_valid && lat < 30) begin
      if (in_ready) saw_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  // Full transaction with out_ready high: accept, latency, value, consume.
  task automatic run_word(input string tag, input logic s, input logic [2:0] e,
                          input logic [3:0] f, input logic [11:0] exp_d);
    int   lat;
    logic saw;
    chk({tag, "_ready_before"}, in_ready, 1'b1);
    send(s, e, f);
    wait_valid(lat, saw);
    chk({tag, "_latency"}, lat, e + 1);
    chk({tag, "_busy_ready"}, saw, 1'b0);
    chk({tag, "_D"}, D, exp_d);
    @(negedge clk);
    chk({tag, "_ready_after"}, in_ready, 1'b1);
    chk({tag, "_valid_after"}, out_valid, 1'b0);
  endtask

  initial begin
    int   lat;
    logic saw;
    int   cyc;
    logic rs;
    logic [2:0] re;
    logic [3:0] rf;

    rst = 1'b1; in_valid = 1'b0; S = 1'b0; E = 3'd0; F = 4'd0; out_ready = 1'b0;
    #12;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_D", D, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    run_word("e0_f9", 1'b0, 3'd0, 4'd9, 12'h009);
    run_word("e7_f15", 1'b0, 3'd7, 4'd15, 12'h780);
    run_word("neg_e3_f5", 1'b1, 3'd3, 4'd5, 12'hFD8);
    run_word("neg_zero", 1'b1, 3'd5, 4'd0, 12'h000);

    // Backpressure: hold the result while out_ready is low and ignore new input.
    out_ready = 1'b0;
    send(1'b1, 3'd7, 4'd15);
    wait_valid(lat, saw);
    chk("bp_latency", lat, 8);
    chk("bp_D", D, 12'h880);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        S = 1'b0; E = 3'd1; F = 4'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_D", D, 12'h880);
      chk("bp_hold_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("bp_single_transfer", out_valid, 1'b0);

    // Asynchronous reset in the third SHIFT cycle of an E=6 word.
    send(1'b1, 3'd6, 4'd7);
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy_ready", in_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_async_ready", in_ready, 1'b1);
    chk("rst_async_valid", out_valid, 1'b0);
    chk("rst_async_D", D, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_no_partial", out_valid, 1'b0);
    run_word("after_rst", 1'b0, 3'd1, 4'd3, 12'h006);

    // Back-to-back with in_valid and out_ready held high.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      re = 3'($urandom_range(0, 7));
      rf = 4'($urandom_range(0, 15));
      chk("b2b_ready", in_ready, 1'b1);
      S = rs; E = re; F = rf;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!out_valid && cyc < 30);
      chk("b2b_D", D, model(rs, re, rf));
      @(negedge clk);
      cyc++;
      chk("b2b_period", cyc, re + 3);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drained", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_to_linear.md
# fp_to_linear

Sequential decoder from the team's 8-bit floating-point format (sign S, 3-bit exponent E, 4-bit significand F) back to a 12-bit two's-complement linear value. It is the inverse of the linear-to-floating-point encoder in the converter datapath. It accepts one encoded word at a time over a valid/ready handshake, shifts the significand one bit per cycle, applies the sign, and presents the result on a held valid/ready output.

## Interface
- No parameters. Widths are fixed by the 1/3/4-bit float format and the 12-bit linear format.
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  S/E/F hold a word to decode
- in_ready  output  1  block can accept a word; high only in IDLE
- S  input  1  sign (1 = negative)
- E  input  3  exponent, 0..7
- F  input  4  significand, 0..15
- out_valid  output  1  D holds a finished result; high only in DONE
- out_ready  input  1  consumer takes D this cycle
- D  output  12  two's-complement result, registered

## Operation
- Decoded value: D = (S ? -1 : +1) × F × 2^E.
  - Magnitude range is 0..1920 (15 × 128), so D always fits in 12 bits.
  - No saturation or overflow path exists.
- Internal registers:
  - mag[11:0]: working magnitude
  - cnt[2:0]: remaining shifts
  - sgn: latched sign
  - state: 2 bits
- States:
  - IDLE
    - in_ready = 1.
    - On in_valid at a rising edge: mag ← {8'b0, F}, cnt ← E, sgn ← S.
    - Next state is SHIFT if E ≠ 0, else FIX.
    - Without in_valid, stay in IDLE.
  - SHIFT
    - Each edge: mag ← mag << 1, cnt ← cnt − 1.
    - When cnt == 1 at the edge, next state is FIX.
    - Exactly E shift edges occur.
  - FIX
    - D ← sgn ? (~mag + 1) : mag.
    - Next state is DONE.
    - S=1 with F=0 yields D = 0 (no negative zero).
  - DONE
    - out_valid = 1; D and all state are held stable.
    - On out_ready at an edge, next state is IDLE.
- Input sampling:
  - S/E/F are sampled only on the accepting edge.
  - Changes to S/E/F or in_valid outside IDLE are ignored.
- in_ready and out_valid are pure decodes of the state register. There is no combinational path from in_valid or out_ready to any output.
- Reset (asynchronous, any state, including mid-SHIFT):
  - state = IDLE, mag = 0, cnt = 0, sgn = 0, D = 0.
  - in_ready = 1 and out_valid = 0 immediately.
  - Any in-flight word is discarded; no partial result is ever presented.
- Do not use X/don't-care assignments. All registers have defined reset values.

## Timing
- Accept edge: the edge on which in_valid && in_ready is high. Call it edge 0.
- out_valid rises after edge E+1: E SHIFT edges plus one FIX edge.
  - E=0: valid after 1 edge.
  - E=7: valid after 8 edges.
- Consume edge: the edge on which out_valid && out_ready is high. in_ready is high in the following cycle, so at most one word is in flight.
- Minimum period per word with out_ready tied high is E+3 cycles:
  - 1 cycle IDLE
  - E cycles SHIFT
  - 1 cycle FIX
  - 1 cycle DONE
- Backpressure: out_valid and D stay asserted and constant for any number of cycles while out_ready is low. in_ready stays low for that whole time.
- out_ready high outside DONE has no effect.
- Reset values of outputs: in_ready = 1, out_valid = 0, D = 12'h000.

## Test plan
- S=0, E=0, F=9 accepted with out_ready=1 → out_valid high 1 edge after accept, D = 12'h009. in_ready returns 1 edge after the consume edge.
- S=0, E=7, F=15 → out_valid after 8 edges, D = 12'h780 (1920). Check that in_ready stays 0 throughout.
- S=1, E=3, F=5 → D = 12'hFD8 (−40). S=1, E=5, F=0 → D = 12'h000.
- Backpressure: S=1, E=7, F=15 with out_ready=0 for 6 cycles after out_valid → D = 12'h880 (−1920) held stable. in_valid pulsed with new data meanwhile is ignored. Releasing out_ready gives exactly one transfer.
- Reset asserted asynchronously in the 3rd SHIFT cycle of an E=6 word → in_ready=1, out_valid=0, D=0 without waiting for a clock edge. Next word S=0, E=1, F=3 → D = 12'h006.
- Back-to-back: 16 random words with in_valid and out_ready both held high → each D matches the formula, each period is E+3 cycles, and no word is dropped or duplicated.
